// File: rtl/chacha_stream_xor_pkg.sv
// rtl/chacha_stream_xor_pkg.sv - shared constants and state encoding for the ChaCha stream XOR initiator
//
// Purpose: load/stream sizes, config address map and FSM state type shared by
// chacha_stream_xor and chacha_cfg_regs.
// Ports: none (package).

package chacha_stream_xor_pkg;

    localparam int LOAD_BYTES  = 48;   // key 32 + counter 4 + nonce 12
    localparam int BLOCK_BYTES = 64;   // keystream bytes per block

    localparam int KEY_BASE    = 0;
    localparam int CTR_BASE    = 32;
    localparam int NONCE_BASE  = 36;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_NEXT   = 3'd4
    } state_e;

endpackage

// File: rtl/chacha_cfg_regs.sv
// rtl/chacha_cfg_regs.sv - 48-byte key/counter/nonce store with counter increment
//
// Purpose: holds the bytes shifted into the core each block. The block counter
// lives in bytes CTR_BASE..CTR_BASE+3 (little-endian) so the load sequence reads
// the live counter directly.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (clears every byte)
//   we_i             write one byte at waddr_i (addresses >= LOAD_BYTES ignored)
//   waddr_i, wdata_i write address / data
//   inc_i            advance the counter by one (mod 2^32)
//   rd_idx_i         combinational read index
//   rd_data_o        byte at rd_idx_i
//   ctr_o            assembled 32-bit counter
//   wrap_o           counter is all-ones, so the next increment wraps to 0

module chacha_cfg_regs
    import chacha_stream_xor_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [5:0]  waddr_i,
    input  logic [7:0]  wdata_i,
    input  logic        inc_i,
    input  logic [5:0]  rd_idx_i,
    output logic [7:0]  rd_data_o,
    output logic [31:0] ctr_o,
    output logic        wrap_o
);

    logic [7:0]  bytes_q [LOAD_BYTES];
    logic [31:0] ctr_inc;

    assign ctr_o   = {bytes_q[CTR_BASE + 3], bytes_q[CTR_BASE + 2],
                      bytes_q[CTR_BASE + 1], bytes_q[CTR_BASE]};
    assign ctr_inc = ctr_o + 32'd1;
    assign wrap_o  = (ctr_o == 32'hFFFF_FFFF);

    assign rd_data_o = (rd_idx_i < 6'(LOAD_BYTES)) ? bytes_q[rd_idx_i] : 8'h00;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LOAD_BYTES; i++) begin
                bytes_q[i] <= 8'h00;
            end
        end else if (inc_i) begin
            bytes_q[CTR_BASE]     <= ctr_inc[7:0];
            bytes_q[CTR_BASE + 1] <= ctr_inc[15:8];
            bytes_q[CTR_BASE + 2] <= ctr_inc[23:16];
            bytes_q[CTR_BASE + 3] <= ctr_inc[31:24];
        end else if (we_i && (waddr_i < 6'(LOAD_BYTES))) begin
            bytes_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/chacha_stream_xor.sv
// rtl/chacha_stream_xor.sv - host initiator that loads the ChaCha core and XORs its keystream with a byte stream
//
// Purpose: loads key/counter/nonce into the byte-serial ChaCha core, waits for
// its ready, then reads the 64 keystream bytes one per accepted plaintext byte,
// emitting ciphertext. Advances the block counter and reloads until stopped or
// the counter wraps.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   cfg_we_i/cfg_addr_i/cfg_wdata_i config byte write (IDLE only)
//   start_i, stop_i                 begin streaming / abort to IDLE
//   busy_o, ctr_out_o, wrap_err_o   status
//   pt_data_i/pt_valid_i/pt_ready_o plaintext stream in
//   ct_data_o/ct_valid_o/ct_ready_i ciphertext stream out
//   core_data_in_o/core_write_o     byte write port to the core
//   core_read_o                     keystream byte advance to the core
//   core_data_out_i/core_ready_i    keystream byte / block ready from the core

module chacha_stream_xor
    import chacha_stream_xor_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_we_i,
    input  logic [5:0]  cfg_addr_i,
    input  logic [7:0]  cfg_wdata_i,
    input  logic        start_i,
    input  logic        stop_i,
    output logic        busy_o,
    output logic [31:0] ctr_out_o,
    output logic        wrap_err_o,
    input  logic [7:0]  pt_data_i,
    input  logic        pt_valid_i,
    output logic        pt_ready_o,
    output logic [7:0]  ct_data_o,
    output logic        ct_valid_o,
    input  logic        ct_ready_i,
    output logic [7:0]  core_data_in_o,
    output logic        core_write_o,
    output logic        core_read_o,
    input  logic [7:0]  core_data_out_i,
    input  logic        core_ready_i
);

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        wait_first_q;
    logic [7:0]  ct_data_q, ct_data_d;
    logic        ct_valid_q, ct_valid_d;
    logic        wrap_err_q, wrap_err_d;

    logic        xfer;
    logic        cfg_we;
    logic        ctr_inc;
    logic [7:0]  cfg_rd;
    logic        cfg_wrap;

    chacha_cfg_regs u_cfg (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (cfg_we),
        .waddr_i   (cfg_addr_i),
        .wdata_i   (cfg_wdata_i),
        .inc_i     (ctr_inc),
        .rd_idx_i  (idx_q),
        .rd_data_o (cfg_rd),
        .ctr_o     (ctr_out_o),
        .wrap_o    (cfg_wrap)
    );

    // Config is only writable while idle; the counter advances in NEXT unless aborted.
    assign cfg_we  = cfg_we_i && (state_q == ST_IDLE);
    assign ctr_inc = (state_q == ST_NEXT) && !stop_i;

    // State register and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            idx_q        <= 6'd0;
            cnt_q        <= 7'd0;
            wait_first_q <= 1'b0;
            ct_data_q    <= 8'h00;
            ct_valid_q   <= 1'b0;
            wrap_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            // WAIT is only entered from LOAD, so this marks its first cycle.
            wait_first_q <= (state_q == ST_LOAD);
            ct_data_q    <= ct_data_d;
            ct_valid_q   <= ct_valid_d;
            wrap_err_q   <= wrap_err_d;
        end
    end

    // Next-state logic; stop overrides every transition.
    always_comb begin
        state_d = state_q;
        if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (start_i) state_d = ST_LOAD;
                ST_LOAD:   if (idx_q == 6'(LOAD_BYTES - 1)) state_d = ST_WAIT;
                ST_WAIT:   if (!wait_first_q && core_ready_i) state_d = ST_STREAM;
                ST_STREAM: if (xfer && (cnt_q == 7'(BLOCK_BYTES - 1))) state_d = ST_NEXT;
                ST_NEXT:   state_d = cfg_wrap ? ST_IDLE : ST_LOAD;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs; strobes are suppressed in the stop cycle itself.
    always_comb begin
        busy_o         = (state_q != ST_IDLE);
        core_write_o   = (state_q == ST_LOAD) && !stop_i;
        core_data_in_o = core_write_o ? cfg_rd : 8'h00;
        pt_ready_o     = (state_q == ST_STREAM) && !stop_i && (!ct_valid_q || ct_ready_i);
        xfer           = pt_ready_o && pt_valid_i;
        core_read_o    = xfer;
        ct_data_o      = ct_data_q;
        ct_valid_o     = ct_valid_q;
        wrap_err_o     = wrap_err_q;
    end

    // Datapath next values. Indices return to 0 whenever their state is left,
    // so each LOAD/STREAM entry starts from zero.
    always_comb begin
        idx_d      = (state_q == ST_LOAD) ? idx_q + 6'd1 : 6'd0;
        cnt_d      = (state_q == ST_STREAM) ? cnt_q + {6'd0, xfer} : 7'd0;
        ct_data_d  = ct_data_q;
        ct_valid_d = ct_valid_q;
        if (xfer) begin
            ct_data_d  = pt_data_i ^ core_data_out_i;
            ct_valid_d = 1'b1;
        end else if (ct_ready_i) begin
            ct_valid_d = 1'b0;
        end
        wrap_err_d = wrap_err_q;
        if ((state_q == ST_IDLE) && start_i && !stop_i) begin
            wrap_err_d = 1'b0;
        end else if (ctr_inc && cfg_wrap) begin
            wrap_err_d = 1'b1;
        end
    end

endmodule
